periph_bus: RTL and testbench

PERIPH_BUS -- requirements
Module: periph_bus

---
 rtl/periph_bus.sv | 196 +++++++++++++++++++
 tb/tb_periph_bus.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus.sv
// periph_bus: single-cycle data-memory bus with a 256-word RAM and a small
// peripheral block: timer (TH/TL/TCON), LED, switch input, seven-segment
// register and an optional free-running systick counter.
// Build option: define PERIPH_SYSTICK_EN to include the systick counter;
// without it, reads of the systick address return 0.

module periph_bus (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        rd,
    input  logic        wr,
    input  logic [7:0]  switch,
    output logic [31:0] rdata,
    output logic [7:0]  led,
    output logic [11:0] digi,
    output logic        irqout
);

    // Word index of each peripheral register within the 0x4000_0000 block.
    localparam logic [2:0] IdxTh     = 3'd0;
    localparam logic [2:0] IdxTl     = 3'd1;
    localparam logic [2:0] IdxTcon   = 3'd2;
    localparam logic [2:0] IdxLed    = 3'd3;
    localparam logic [2:0] IdxSwitch = 3'd4;
    localparam logic [2:0] IdxDigi   = 3'd5;
    localparam logic [2:0] IdxTick   = 3'd6;

    // addr[31:5] of the peripheral block base 0x4000_0000.
    localparam logic [26:0] PeriphBase = 27'h200_0000;

    localparam logic [31:0] TlMax = 32'hFFFF_FFFF;

    // ------------------------------------------------------------------
    // Address decode (addr[1:0] is ignored: word accesses only)
    // ------------------------------------------------------------------
    logic       ram_sel;
    logic       periph_hit;
    logic [2:0] reg_idx;
    logic [7:0] ram_idx;

    logic sel_th;
    logic sel_tl;
    logic sel_tcon;
    logic sel_led;
    logic sel_digi;

    assign ram_sel    = (addr[31:10] == 22'd0);
    assign periph_hit = (addr[31:5] == PeriphBase);
    assign reg_idx    = addr[4:2];
    assign ram_idx    = addr[9:2];

    assign sel_th   = periph_hit && (reg_idx == IdxTh);
    assign sel_tl   = periph_hit && (reg_idx == IdxTl);
    assign sel_tcon = periph_hit && (reg_idx == IdxTcon);
    assign sel_led  = periph_hit && (reg_idx == IdxLed);
    assign sel_digi = periph_hit && (reg_idx == IdxDigi);

    // ------------------------------------------------------------------
    // Data RAM: 256 x 32, contents survive reset
    // ------------------------------------------------------------------
    logic [31:0] mem [256];

    // RAM write port; reset also blocks stores so nothing changes during reset.
    always_ff @(posedge clk) begin
        if (!reset && wr && ram_sel) begin
            mem[ram_idx] <= wdata;
        end
    end

    // ------------------------------------------------------------------
    // Peripheral registers
    // ------------------------------------------------------------------
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [7:0]  led_q, led_d;
    logic [11:0] digi_q, digi_d;

    logic        timer_en;
    logic        timer_wrap;
    logic        cpu_owns_timer;

    assign timer_en   = tcon_q[0];
    assign timer_wrap = timer_en && (tl_q == TlMax);
    // A store to TL or TCON overrides the whole timer update of this cycle,
    // including any irq-status set that an overflow would have produced.
    assign cpu_owns_timer = wr && (sel_tl || sel_tcon);

    // Next-state for timer and I/O registers: timer event first, CPU store last.
    always_comb begin
        th_d   = th_q;
        tl_d   = tl_q;
        tcon_d = tcon_q;
        led_d  = led_q;
        digi_d = digi_q;

        if (timer_en && !cpu_owns_timer) begin
            if (timer_wrap) begin
                tl_d = th_q;
                if (tcon_q[1]) begin
                    tcon_d[2] = 1'b1;
                end
            end else begin
                tl_d = tl_q + 32'd1;
            end
        end

        if (wr) begin
            if (sel_th) begin
                th_d = wdata;
            end
            if (sel_tl) begin
                tl_d = wdata;
            end
            if (sel_tcon) begin
                tcon_d = wdata[2:0];
            end
            if (sel_led) begin
                led_d = wdata[7:0];
            end
            if (sel_digi) begin
                digi_d = wdata[11:0];
            end
        end
    end

    // Register update; reset beats any store or timer event.
    always_ff @(posedge clk) begin
        if (reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            led_q  <= '0;
            digi_q <= '0;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            led_q  <= led_d;
            digi_q <= digi_d;
        end
    end

    // ------------------------------------------------------------------
    // Optional systick counter
    // ------------------------------------------------------------------
    logic [31:0] systick_rd;

`ifdef PERIPH_SYSTICK_EN
    logic [31:0] systick_q;

    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            systick_q <= '0;
        end else begin
            systick_q <= systick_q + 32'd1;
        end
    end

    assign systick_rd = systick_q;
`else
    assign systick_rd = '0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign led    = led_q;
    assign digi   = digi_q;
    assign irqout = tcon_q[2];

    // Zero-latency read mux; shows the pre-store value when rd and wr coincide.
    always_comb begin
        rdata = '0;
        if (rd) begin
            if (ram_sel) begin
                rdata = mem[ram_idx];
            end else if (periph_hit) begin
                case (reg_idx)
                    IdxTh:     rdata = th_q;
                    IdxTl:     rdata = tl_q;
                    IdxTcon:   rdata = {29'd0, tcon_q};
                    IdxLed:    rdata = {24'd0, led_q};
                    IdxSwitch: rdata = {24'd0, switch};
                    IdxDigi:   rdata = {20'd0, digi_q};
                    IdxTick:   rdata = systick_rd;
                    default:   rdata = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_periph_bus.sv
// Self-checking bench for periph_bus: RAM, I/O registers, timer reload/irq,
// write priority and reset. Expected read data is queued when a read is
// issued and compared when rdata has settled.

module tb_periph_bus;

    localparam logic [31:0] ATh   = 32'h4000_0000;
    localparam logic [31:0] ATl   = 32'h4000_0004;
    localparam logic [31:0] ATcon = 32'h4000_0008;
    localparam logic [31:0] ALed  = 32'h4000_000C;
    localparam logic [31:0] ASw   = 32'h4000_0010;
    localparam logic [31:0] ADigi = 32'h4000_0014;
    localparam logic [31:0] ATick = 32'h4000_0018;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [7:0]  switch;
    logic [31:0] rdata;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];

    periph_bus dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .rd     (rd),
        .wr     (wr),
        .switch (switch),
        .rdata  (rdata),
        .led    (led),
        .digi   (digi),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    // Issue a read and compare rdata against the oldest queued expectation.
    task automatic read_raw(input logic [31:0] a);
        sb_item_t it;
        addr = a;
        rd   = 1'b1;
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", rdata, 32'hxxxx_xxxx);
        end else begin
            it = sb_q.pop_front();
            check_eq(it.tag, rdata, it.exp);
        end
        rd = 1'b0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        read_raw(a);
    endtask

    // Store: drive at the falling edge, commit on the next rising edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    logic [31:0] ram_addr [6];
    logic [31:0] ram_val  [6];
    logic [31:0] tick_one;

    initial begin
        reset  = 1'b1;
        addr   = '0;
        wdata  = '0;
        rd     = 1'b0;
        wr     = 1'b0;
        switch = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check_eq("rst_led", {24'd0, led}, 32'd0);
        check_eq("rst_digi", {20'd0, digi}, 32'd0);
        check_eq("rst_irq", {31'd0, irqout}, 32'd0);
        bus_read("rst_th", ATh, 32'd0);
        bus_read("rst_tl", ATl, 32'd0);
        bus_read("rst_tcon", ATcon, 32'd0);

        // RAM basics and byte-offset aliasing
        bus_write(32'h0000_0010, 32'hDEAD_BEEF);
        bus_read("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        bus_read("ram_400", 32'h0000_0400, 32'd0);
        addr = 32'h0000_0010;
        rd   = 1'b0;
        #1;
        check_eq("ram_rd0", rdata, 32'd0);

        // Read and write together: old data visible, new data next cycle
        addr  = 32'h0000_0010;
        wdata = 32'h1234_5678;
        rd    = 1'b1;
        wr    = 1'b1;
        sb_push("rw_old", 32'hDEAD_BEEF);
        read_raw(32'h0000_0010);
        rd = 1'b1;
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        bus_read("rw_new", 32'h0000_0010, 32'h1234_5678);

        // RAM pattern sweep including the last word
        ram_addr = '{32'h000, 32'h004, 32'h0FC, 32'h200, 32'h3F8, 32'h3FC};
        for (int i = 0; i < 6; i++) begin
            ram_val[i] = $urandom();
            bus_write(ram_addr[i], ram_val[i]);
            sb_push($sformatf("ram_sweep%0d", i), ram_val[i]);
        end
        for (int i = 0; i < 6; i++) begin
            read_raw(ram_addr[i] | 32'(i % 4));
        end

        // I/O registers
        switch = 8'hA5;
        bus_read("sw_rd", ASw, 32'h0000_00A5);
        bus_write(ASw, 32'h0000_0011);
        bus_read("sw_ro", ASw, 32'h0000_00A5);
        bus_write(ALed, 32'h0000_01FF);
        check_eq("led_port", {24'd0, led}, 32'h0000_00FF);
        bus_read("led_rd", ALed, 32'h0000_00FF);
        bus_write(ADigi, 32'hFFFF_1ABC);
        check_eq("digi_port", {20'd0, digi}, 32'h0000_0ABC);
        bus_read("digi_rd", ADigi, 32'h0000_0ABC);
        bus_read("unmapped", 32'h4000_0020, 32'd0);
        bus_read("unmapped2", 32'h8000_0000, 32'd0);
        addr = ALed;
        rd   = 1'b0;
        #1;
        check_eq("io_rd0", rdata, 32'd0);

        // Timer reload and irq
        bus_write(ATh, 32'hFFFF_FFFD);
        bus_write(ATl, 32'hFFFF_FFFE);
        bus_write(ATcon, 32'd3);
        bus_read("tmr_tl0", ATl, 32'hFFFF_FFFE);
        tick();
        bus_read("tmr_tl1", ATl, 32'hFFFF_FFFF);
        check_eq("tmr_irq1", {31'd0, irqout}, 32'd0);
        tick();
        bus_read("tmr_reload", ATl, 32'hFFFF_FFFD);
        check_eq("tmr_irq2", {31'd0, irqout}, 32'd1);
        bus_read("tmr_tcon", ATcon, 32'd7);

        // Acknowledge: irq clears, timer continues
        bus_write(ATcon, 32'd3);
        check_eq("ack_irq", {31'd0, irqout}, 32'd0);
        bus_read("ack_tl", ATl, 32'hFFFF_FFFD);
        tick();
        bus_read("ack_count", ATl, 32'hFFFF_FFFE);
        tick();
        bus_read("pre_ovf", ATl, 32'hFFFF_FFFF);

        // TL store in the overflow cycle wins and suppresses the irq
        bus_write(ATl, 32'h0000_0005);
        bus_read("prio_tl", ATl, 32'h0000_0005);
        check_eq("prio_irq", {31'd0, irqout}, 32'd0);
        tick();
        bus_read("prio_next", ATl, 32'h0000_0006);

        // Freeze with enable off
        bus_write(ATcon, 32'd0);
        tick();
        tick();
        bus_read("freeze_tl", ATl, 32'h0000_0006);

        // Overflow with irq disabled reloads only
        bus_write(ATh, 32'h0000_0100);
        bus_write(ATl, 32'hFFFF_FFFF);
        bus_write(ATcon, 32'd1);
        tick();
        bus_read("noirq_reload", ATl, 32'h0000_0100);
        check_eq("noirq_irq", {31'd0, irqout}, 32'd0);

        // Reset during an overflow with a simultaneous LED store
        bus_write(ATcon, 32'd0);
        bus_write(ATh, 32'h0000_0077);
        bus_write(ATl, 32'hFFFF_FFFE);
        bus_write(ATcon, 32'd3);
        tick();
        bus_read("rst_pre_ovf", ATl, 32'hFFFF_FFFF);
        reset = 1'b1;
        bus_write(ALed, 32'h0000_003C);
        reset = 1'b0;
        check_eq("rst2_led", {24'd0, led}, 32'd0);
        check_eq("rst2_digi", {20'd0, digi}, 32'd0);
        check_eq("rst2_irq", {31'd0, irqout}, 32'd0);
        bus_read("rst2_th", ATh, 32'd0);
        bus_read("rst2_tl", ATl, 32'd0);
        bus_read("rst2_tcon", ATcon, 32'd0);
        bus_read("rst2_tick0", ATick, 32'd0);
`ifdef PERIPH_SYSTICK_EN
        tick_one = 32'd1;
`else
        tick_one = 32'd0;
`endif
        tick();
        bus_read("rst2_tick1", ATick, tick_one);
        tick();
        bus_read("rst2_tick2", ATick, tick_one << 1);
        bus_write(ATick, 32'h0000_1234);
        bus_read("tick_ro", ATick, tick_one * 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
